// File: rtl/seq_chk_pkg.sv
// Shared definitions for the sequence response checker.
// Holds the parameter defaults and the per-slot result encoding used
// between seq_slot and seq_response_checker.
package seq_chk_pkg;

    localparam int MIN_DLY_DEF   = 1;
    localparam int MAX_DLY_DEF   = 4;
    localparam int NUM_SLOTS_DEF = 4;
    localparam int CNT_W_DEF     = 16;

    // Outcome of one slot in the current cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        MATCH = 2'd2,
        FAIL  = 2'd3
    } slot_result_e;

endpackage

// File: rtl/seq_slot.sv
// One attempt tracker for trig |-> ##[MIN_DLY:MAX_DLY] resp.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   i_load         : start an attempt (taken only when the slot is free)
//   i_resp         : consequent sample
//   o_valid        : registered valid bit
//   o_result       : combinational outcome for the current cycle
module seq_slot
    import seq_chk_pkg::*;
#(
    parameter int MIN_DLY = MIN_DLY_DEF,
    parameter int MAX_DLY = MAX_DLY_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic         i_resp,
    output logic         o_valid,
    output slot_result_e o_result
);

    localparam int AGE_W = $clog2(MAX_DLY + 1);

    logic             r_valid;
    logic [AGE_W-1:0] r_age;
    slot_result_e     w_result;

    // Resolve the attempt: a match takes precedence over a timeout in the
    // same cycle, so a late-but-legal resp still counts as a pass.
    always_comb begin
        w_result = IDLE;
        if (!r_valid) begin
            w_result = IDLE;
        end else if (i_resp && (r_age >= AGE_W'(MIN_DLY))) begin
            w_result = MATCH;
        end else if (r_age == AGE_W'(MAX_DLY)) begin
            w_result = FAIL;
        end else begin
            w_result = PEND;
        end
    end

    // Slot state: load with age 1, clear on resolution, otherwise age.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_age   <= '0;
        end else if (i_load && !r_valid) begin
            r_valid <= 1'b1;
            r_age   <= AGE_W'(1);
        end else if ((w_result == MATCH) || (w_result == FAIL)) begin
            r_valid <= 1'b0;
            r_age   <= '0;
        end else if (r_valid) begin
            r_age   <= r_age + AGE_W'(1);
        end else begin
            r_age   <= r_age;
        end
    end

    assign o_valid  = r_valid;
    assign o_result = w_result;

endmodule

// File: rtl/seq_response_checker.sv
// Checks trig |-> ##[MIN_DLY:MAX_DLY] resp with overlapping attempts.
// Ports:
//   clock, reset_n      : clock and synchronous active-low reset
//   enable              : allows triggers to start attempts
//   trig, resp          : antecedent and consequent samples
//   match, fail         : registered pulses, one cycle after resolution
//   overflow            : sticky, a trigger found no free slot
//   outstanding         : number of attempts in flight
//   pass_cnt, fail_cnt  : saturating totals of resolved attempts
module seq_response_checker
    import seq_chk_pkg::*;
#(
    parameter int MIN_DLY   = MIN_DLY_DEF,
    parameter int MAX_DLY   = MAX_DLY_DEF,
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           trig,
    input  logic                           resp,
    output logic                           match,
    output logic                           fail,
    output logic                           overflow,
    output logic [$clog2(NUM_SLOTS+1)-1:0] outstanding,
    output logic [CNT_W-1:0]               pass_cnt,
    output logic [CNT_W-1:0]               fail_cnt
);

    localparam int OUT_W = $clog2(NUM_SLOTS + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [NUM_SLOTS-1:0] w_valid;
    logic [NUM_SLOTS-1:0] w_load;
    slot_result_e         w_result [NUM_SLOTS];
    logic                 w_found;
    logic                 w_drop;
    logic [OUT_W-1:0]     w_out_cnt;
    logic [OUT_W-1:0]     w_nmatch;
    logic [OUT_W-1:0]     w_nfail;
    logic [SUM_W-1:0]     w_pass_sum;
    logic [SUM_W-1:0]     w_fail_sum;

    logic                 r_match;
    logic                 r_fail;
    logic                 r_overflow;
    logic [CNT_W-1:0]     r_pass_cnt;
    logic [CNT_W-1:0]     r_fail_cnt;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        seq_slot #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY)
        ) u_slot (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_load   (w_load[g]),
            .i_resp   (resp),
            .o_valid  (w_valid[g]),
            .o_result (w_result[g])
        );
    end

    // Lowest-index free slot wins; freedom uses the registered valid bits,
    // so a slot resolving this cycle is not reused until the next one.
    always_comb begin
        w_load  = '0;
        w_found = 1'b0;
        w_drop  = 1'b0;
        if (enable && trig) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!w_valid[i] && !w_found) begin
                    w_load[i] = 1'b1;
                    w_found   = 1'b1;
                end else begin
                    w_load[i] = 1'b0;
                end
            end
            w_drop = !w_found;
        end else begin
            w_drop = 1'b0;
        end
    end

    // Popcounts of in-flight, matching and failing slots.
    always_comb begin
        w_out_cnt = '0;
        w_nmatch  = '0;
        w_nfail   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_out_cnt = w_out_cnt + OUT_W'(w_valid[i]);
            w_nmatch  = w_nmatch + OUT_W'(w_result[i] == MATCH);
            w_nfail   = w_nfail + OUT_W'(w_result[i] == FAIL);
        end
    end

    // The extra top bit of each sum flags a wrap, which clamps to all-ones.
    assign w_pass_sum = {1'b0, r_pass_cnt} + SUM_W'(w_nmatch);
    assign w_fail_sum = {1'b0, r_fail_cnt} + SUM_W'(w_nfail);

    // Registered result pulses, sticky overflow and saturating counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_match    <= 1'b0;
            r_fail     <= 1'b0;
            r_overflow <= 1'b0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_match    <= (w_nmatch != '0);
            r_fail     <= (w_nfail != '0);
            r_overflow <= r_overflow | w_drop;
            r_pass_cnt <= w_pass_sum[CNT_W] ? '1 : w_pass_sum[CNT_W-1:0];
            r_fail_cnt <= w_fail_sum[CNT_W] ? '1 : w_fail_sum[CNT_W-1:0];
        end
    end

    assign match       = r_match;
    assign fail        = r_fail;
    assign overflow    = r_overflow;
    assign outstanding = w_out_cnt;
    assign pass_cnt    = r_pass_cnt;
    assign fail_cnt    = r_fail_cnt;

endmodule

// File: tb/tb_seq_response_checker.sv
// Self-checking bench for seq_response_checker. A reference model keeps the
// birth cycle of each outstanding attempt and resolves it by elapsed time.
module tb_seq_response_checker;

    localparam int MIN_DLY   = 1;
    localparam int MAX_DLY   = 4;
    localparam int NUM_SLOTS = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       trig = 1'b0;
    logic       resp = 1'b0;
    logic       match;
    logic       fail;
    logic       overflow;
    logic [2:0] outstanding;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int q_birth[$];
    int cyc = 0;
    int m_match = 0, m_fail = 0, m_ovf = 0, m_pass = 0, m_failc = 0;

    seq_response_checker #(
        .MIN_DLY   (MIN_DLY),
        .MAX_DLY   (MAX_DLY),
        .NUM_SLOTS (NUM_SLOTS),
        .CNT_W     (CNT_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .trig        (trig),
        .resp        (resp),
        .match       (match),
        .fail        (fail),
        .overflow    (overflow),
        .outstanding (outstanding),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic rn, input logic en, input logic tg, input logic rs);
        int nm;
        int nf;
        int old_n;
        int keep[$];
        if (!rn) begin
            q_birth.delete();
            m_match = 0; m_fail = 0; m_ovf = 0; m_pass = 0; m_failc = 0;
        end else begin
            nm = 0;
            nf = 0;
            old_n = q_birth.size();
            foreach (q_birth[k]) begin
                int age;
                age = cyc - q_birth[k];
                if (rs && age >= MIN_DLY) nm++;
                else if (age == MAX_DLY) nf++;
                else keep.push_back(q_birth[k]);
            end
            q_birth = keep;
            if (en && tg) begin
                if (old_n < NUM_SLOTS) q_birth.push_back(cyc);
                else m_ovf = 1;
            end
            m_match = (nm > 0) ? 1 : 0;
            m_fail  = (nf > 0) ? 1 : 0;
            m_pass  = (m_pass + nm > CNT_MAX) ? CNT_MAX : m_pass + nm;
            m_failc = (m_failc + nf > CNT_MAX) ? CNT_MAX : m_failc + nf;
        end
        cyc++;
    endtask

    // Drive one cycle of inputs, clock it, then compare every output.
    task automatic step(input logic rn, input logic en, input logic tg, input logic rs);
        reset_n = rn;
        enable  = en;
        trig    = tg;
        resp    = rs;
        model_step(rn, en, tg, rs);
        @(posedge clock);
        #1;
        check_val("match", int'(match), m_match);
        check_val("fail", int'(fail), m_fail);
        check_val("overflow", int'(overflow), m_ovf);
        check_val("outstanding", int'(outstanding), q_birth.size());
        check_val("pass_cnt", int'(pass_cnt), m_pass);
        check_val("fail_cnt", int'(fail_cnt), m_failc);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        check_val("rst_outstanding", int'(outstanding), 0);
        check_val("rst_pass_cnt", int'(pass_cnt), 0);

        // trig at 0, resp at 2 -> match at 3 only
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_val("d_match_c3", int'(match), 1);
        check_val("d_pass_c3", int'(pass_cnt), 1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // trig at 0, resp never -> fail at 5
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("d_fail_c5", int'(fail), 1);
        check_val("d_out_c5", int'(outstanding), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // trig at 0 and 1, resp at 3 -> single pulse, pass_cnt 2
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_val("d_pass2_c4", int'(pass_cnt), 2);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // trig at 0..4 -> 4 outstanding, fifth dropped, overflow sticky
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check_val("d_out4_c4", int'(outstanding), 4);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_val("d_ovf_c5", int'(overflow), 1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // trig and resp together at 0 -> no match, fail at 5
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("d_samecyc_fail", int'(fail), 1);
        check_val("d_samecyc_pass", int'(pass_cnt), 0);

        // reset mid-attempt -> nothing afterwards
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("d_midrst_out", int'(outstanding), 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // randomized traffic, including enable gaps, rare resets and saturation
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic rn, en, tg, rs;
            rn = ($urandom_range(0, 199) != 0);
            en = ($urandom_range(0, 99) < 85);
            tg = ($urandom_range(0, 99) < 50);
            rs = ($urandom_range(0, 99) < 25);
            step(rn, en, tg, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_response_checker.md
SEQ_RESPONSE_CHECKER -- requirements
Module: seq_response_checker

Interface
REQ-001 SHALL have parameter MIN_DLY, default 1, minimum cycles from trigger to response (legal range >= 1).
REQ-002 SHALL have parameter MAX_DLY, default 4, maximum cycles from trigger to response (>= MIN_DLY).
REQ-003 SHALL have parameter NUM_SLOTS, default 4, maximum number of attempts outstanding at once.
REQ-004 SHALL have parameter CNT_W, default 16, width of the result counters.
REQ-005 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  input  1  when high, trigger may start attempts.
REQ-008 SHALL have port trig  input  1  antecedent ("a") sample.
REQ-009 SHALL have port resp  input  1  consequent ("b") sample.
REQ-010 SHALL have port match  output  1  one-cycle pulse: at least one attempt satisfied.
REQ-011 SHALL have port fail  output  1  one-cycle pulse: at least one attempt timed out.
REQ-012 SHALL have port overflow  output  1  sticky: a trigger was dropped because all slots were busy.
REQ-013 SHALL have port outstanding  output  clog2(NUM_SLOTS+1)  number of valid slots.
REQ-014 SHALL have port pass_cnt  output  CNT_W  total attempts satisfied.
REQ-015 SHALL have port fail_cnt  output  CNT_W  total attempts timed out.

Function
REQ-016 SHALL check the property trig |-> ##[MIN_DLY:MAX_DLY] resp for every trigger cycle, with overlapping attempts.
REQ-017 Each slot SHALL hold valid plus an age field of clog2(MAX_DLY+1) bits.
REQ-018 A cycle with enable && trig SHALL load the lowest-index slot whose registered valid is 0, setting valid=1 and age=1.
REQ-019 A slot resolving in the current cycle SHALL NOT count as free for allocation in that cycle.
REQ-020 With no free slot, the trigger SHALL be dropped and overflow SHALL set, remaining high until reset.
REQ-021 For a valid slot, resp high with age >= MIN_DLY SHALL resolve it as a match and clear valid (first-match semantics).
REQ-022 Otherwise, age == MAX_DLY SHALL resolve the slot as a fail and clear valid.
REQ-023 Otherwise, age SHALL increment by 1.
REQ-024 resp in the trigger cycle itself SHALL never satisfy that attempt.
REQ-025 One resp cycle SHALL resolve every valid slot in the window simultaneously.
REQ-026 match and fail SHALL be registered and assert in the cycle after resolution; both may assert together.
REQ-027 pass_cnt and fail_cnt SHALL increase by the number of slots resolved that cycle, with the same one-cycle latency.
REQ-028 pass_cnt and fail_cnt SHALL saturate at all-ones.
REQ-029 outstanding SHALL equal the popcount of the registered valid bits.
REQ-030 enable low SHALL block new attempts only; outstanding attempts SHALL continue to age and resolve.

Reset
REQ-031 With reset_n low at a clock edge, all slots SHALL be invalidated and match, fail, overflow, outstanding, pass_cnt and fail_cnt SHALL be 0.
REQ-032 Reset mid-attempt SHALL discard the attempt without producing a match or fail pulse.
REQ-033 The first trigger SHALL be accepted in the first cycle after reset_n is sampled high.

Structure
REQ-034 Shared package seq_chk_pkg SHALL hold the parameter defaults and the slot result enum (IDLE, PEND, MATCH, FAIL).
REQ-035 SHALL use one sub-module, seq_slot, that tracks a single attempt (load, age, resolve); NUM_SLOTS instances are generated.
REQ-036 Allocation priority, popcount and counters SHALL live in the top level.

Verification
(All with MIN=1, MAX=4, NUM_SLOTS=4, enable=1.)
REQ-037 trig at cycle 0, resp at cycle 2 -> match=1 at cycle 3 only; pass_cnt=1; fail never asserts.
REQ-038 trig at cycle 0, resp never -> fail=1 at cycle 5; fail_cnt=1; outstanding returns to 0 at cycle 5.
REQ-039 trig at cycles 0 and 1, resp at cycle 3 -> one match pulse at cycle 4; pass_cnt=2.
REQ-040 trig at cycles 0-4, resp low -> outstanding=4 at cycle 4; trigger at cycle 4 dropped; overflow=1 from cycle 5 until reset.
REQ-041 trig and resp both at cycle 0, resp low afterwards -> no match; fail at cycle 5.
REQ-042 trig at cycle 0, reset_n low at cycle 2 -> all outputs 0 from cycle 3; no pulse afterwards.
